mem_wb_reg: RTL and testbench
=============================

MEM_WB_REG -- requirements
Module: mem_wb_reg

Interface
REQ-001 Parameter DW, default `D_WIDTH (32), datapath width of read data, ALU result and writeback result.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 i_stall  input  1  hold: pipeline register keeps its contents.
REQ-005 i_flush  input  1  kill: both lanes' captured instructions are discarded; has priority over i_stall.
REQ-006 i_valid1M, i_valid2M  input  1 each  lane 1 (older) / lane 2 (younger) instruction present in MEM.
REQ-007 i_RegWrite1M, i_MemtoReg1M, i_RegWrite2M, i_MemtoReg2M  input  1 each  per-lane writeback controls from MEM.
REQ-008 i_RD1, i_RD2  input  DW each  data-memory read data per lane.
REQ-009 i_ALUOut1M, i_ALUOut2M  input  DW each  ALU result per lane.
REQ-010 i_WA1M, i_WA2M  input  4 each  destination register address per lane.
REQ-011 o_valid1W, o_valid2W  output  1 each  registered lane valid in WB.
REQ-012 o_RegWrite1W, o_RegWrite2W  output  1 each  register-file write enables, already gated by valid and conflict rule.
REQ-013 o_WA1W, o_WA2W  output  4 each  registered destination addresses.
REQ-014 o_Result1W, o_Result2W  output  DW each  writeback data per lane.
REQ-015 o_retire_cnt  output  32  retired-instruction count (present only with RETIRE_CNT_EN).

Function
REQ-016 Latency one cycle: inputs sampled at edge N appear on outputs after edge N.
REQ-017 Capture condition: rst_n=1, i_flush=0, i_stall=0; all lane fields load from inputs.
REQ-018 i_stall=1 and i_flush=0: every registered field, including valids, holds its value.
REQ-019 i_flush=1: o_valid1W, o_valid2W, o_RegWrite1W, o_RegWrite2W load 0; data/address fields hold; applies regardless of i_stall.
REQ-020 Registered RegWrite per lane = i_RegWrite?M AND i_valid?M at capture.
REQ-021 Same-destination conflict: at capture, if both lanes valid, both RegWrite, and i_WA1M==i_WA2M, lane 1 registered RegWrite = 0 (younger lane 2 wins); o_valid1W still 1.
REQ-022 o_Result?W = registered MemtoReg ? registered RD : registered ALUOut, combinational from registers only; no input-to-output combinational path.
REQ-023 All 16 addresses (0..15) are ordinary registers; no address receives special treatment.

Reset
REQ-024 rst_n=0 at an edge: valids, RegWrites, MemtoRegs = 0, WAs = 0, RD/ALUOut registers = 0, so o_Result?W = 0; overrides i_flush and i_stall.
REQ-025 Reset asserted mid-stall discards the held instructions; first capture after release is a normal capture.

Configuration
REQ-026 Macro RETIRE_CNT_EN defined: 32-bit counter o_retire_cnt, reset 0, increments at each capture edge by the number of asserted input valids (0, 1 or 2); no increment on stall, flush or reset; wraps modulo 2^32 (0xFFFFFFFF + 2 -> 0x00000001).
REQ-027 RETIRE_CNT_EN undefined: counter logic and o_retire_cnt port absent; all other behaviour identical.

Verification
REQ-028 Reset: rst_n=0 one edge with all inputs at 1 -> all outputs 0, o_retire_cnt=0.
REQ-029 Pass-through: lane1 valid, RegWrite=1, MemtoReg=1, RD=0xDEADBEEF, WA=3; lane2 valid, MemtoReg=0, ALUOut=0x12, WA=5 -> next cycle o_Result1W=0xDEADBEEF, o_WA1W=3, o_Result2W=0x12, both RegWrite=1, count +2.
REQ-030 Conflict: both lanes RegWrite, WA=7 -> o_RegWrite1W=0, o_RegWrite2W=1, o_valid1W=1; WA1=7, WA2=8 -> both RegWrite=1.
REQ-031 Stall/flush: capture WA1=4, then i_stall=1 three cycles with changed inputs -> outputs unchanged, count unchanged; then i_stall=1 and i_flush=1 -> valids and RegWrites 0, count unchanged.
REQ-032 Invalid gating: i_valid1M=0, i_RegWrite1M=1 -> o_RegWrite1W=0, count +0 for lane 1.
REQ-033 Wrap (RETIRE_CNT_EN): force counter to 0xFFFFFFFF via 2^32-1 retirements or backdoor, capture two valid lanes -> o_retire_cnt=0x00000001.

Source files
------------

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register for a dual-issue pipeline: per-lane writeback state with stall/flush control.
// Optional retired-instruction counter enabled by defining the RETIRE_CNT_EN macro.
`ifndef D_WIDTH
`define D_WIDTH 32
`endif

module mem_wb_reg #(
  parameter int DW = `D_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_stall,
  input  logic          i_flush,
  input  logic          i_valid1M,
  input  logic          i_valid2M,
  input  logic          i_RegWrite1M,
  input  logic          i_MemtoReg1M,
  input  logic          i_RegWrite2M,
  input  logic          i_MemtoReg2M,
  input  logic [DW-1:0] i_RD1,
  input  logic [DW-1:0] i_RD2,
  input  logic [DW-1:0] i_ALUOut1M,
  input  logic [DW-1:0] i_ALUOut2M,
  input  logic [3:0]    i_WA1M,
  input  logic [3:0]    i_WA2M,
  output logic          o_valid1W,
  output logic          o_valid2W,
  output logic          o_RegWrite1W,
  output logic          o_RegWrite2W,
  output logic [3:0]    o_WA1W,
  output logic [3:0]    o_WA2W,
  output logic [DW-1:0] o_Result1W,
  output logic [DW-1:0] o_Result2W
`ifdef RETIRE_CNT_EN
  ,
  output logic [31:0]   o_retire_cnt
`endif
);

  typedef struct packed {
    logic          valid;
    logic          reg_write;
    logic          mem_to_reg;
    logic [3:0]    wa;
    logic [DW-1:0] rd;
    logic [DW-1:0] alu_out;
  } lane_t;

  lane_t lane1_q, lane2_q;
  lane_t lane1_d, lane2_d;
  logic  capture;
  logic  wa_conflict;

  assign capture = !i_flush && !i_stall;

  // Both lanes writing the same register: the younger lane 2 must be the one that lands.
  assign wa_conflict = i_valid1M && i_valid2M && i_RegWrite1M && i_RegWrite2M &&
                       (i_WA1M == i_WA2M);

  always_comb begin
    lane1_d            = '0;
    lane1_d.valid      = i_valid1M;
    lane1_d.reg_write  = i_RegWrite1M && i_valid1M && !wa_conflict;
    lane1_d.mem_to_reg = i_MemtoReg1M;
    lane1_d.wa         = i_WA1M;
    lane1_d.rd         = i_RD1;
    lane1_d.alu_out    = i_ALUOut1M;

    lane2_d            = '0;
    lane2_d.valid      = i_valid2M;
    lane2_d.reg_write  = i_RegWrite2M && i_valid2M;
    lane2_d.mem_to_reg = i_MemtoReg2M;
    lane2_d.wa         = i_WA2M;
    lane2_d.rd         = i_RD2;
    lane2_d.alu_out    = i_ALUOut2M;
  end

  // A flush only kills the instructions; data and addresses are left as they were.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane1_q <= '0;
      lane2_q <= '0;
    end else if (i_flush) begin
      lane1_q.valid     <= 1'b0;
      lane1_q.reg_write <= 1'b0;
      lane2_q.valid     <= 1'b0;
      lane2_q.reg_write <= 1'b0;
    end else if (!i_stall) begin
      lane1_q <= lane1_d;
      lane2_q <= lane2_d;
    end
  end

  assign o_valid1W    = lane1_q.valid;
  assign o_valid2W    = lane2_q.valid;
  assign o_RegWrite1W = lane1_q.reg_write;
  assign o_RegWrite2W = lane2_q.reg_write;
  assign o_WA1W       = lane1_q.wa;
  assign o_WA2W       = lane2_q.wa;
  assign o_Result1W   = lane1_q.mem_to_reg ? lane1_q.rd : lane1_q.alu_out;
  assign o_Result2W   = lane2_q.mem_to_reg ? lane2_q.rd : lane2_q.alu_out;

`ifdef RETIRE_CNT_EN
  logic [31:0] retire_cnt_q;
  logic [31:0] retire_inc;

  assign retire_inc = {31'd0, i_valid1M} + {31'd0, i_valid2M};

  // Counts instructions entering WB; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_cnt_q <= '0;
    end else if (capture) begin
      retire_cnt_q <= retire_cnt_q + retire_inc;
    end
  end

  assign o_retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_reg.sv
// Directed self-checking bench for mem_wb_reg; counter checks build only with RETIRE_CNT_EN.
`timescale 1ns/1ps

module tb_mem_wb_reg;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n, i_stall, i_flush;
  logic          i_valid1M, i_valid2M;
  logic          i_RegWrite1M, i_MemtoReg1M, i_RegWrite2M, i_MemtoReg2M;
  logic [DW-1:0] i_RD1, i_RD2, i_ALUOut1M, i_ALUOut2M;
  logic [3:0]    i_WA1M, i_WA2M;
  logic          o_valid1W, o_valid2W, o_RegWrite1W, o_RegWrite2W;
  logic [3:0]    o_WA1W, o_WA2W;
  logic [DW-1:0] o_Result1W, o_Result2W;
`ifdef RETIRE_CNT_EN
  logic [31:0]   o_retire_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_reg #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .i_stall(i_stall), .i_flush(i_flush),
    .i_valid1M(i_valid1M), .i_valid2M(i_valid2M),
    .i_RegWrite1M(i_RegWrite1M), .i_MemtoReg1M(i_MemtoReg1M),
    .i_RegWrite2M(i_RegWrite2M), .i_MemtoReg2M(i_MemtoReg2M),
    .i_RD1(i_RD1), .i_RD2(i_RD2), .i_ALUOut1M(i_ALUOut1M), .i_ALUOut2M(i_ALUOut2M),
    .i_WA1M(i_WA1M), .i_WA2M(i_WA2M),
    .o_valid1W(o_valid1W), .o_valid2W(o_valid2W),
    .o_RegWrite1W(o_RegWrite1W), .o_RegWrite2W(o_RegWrite2W),
    .o_WA1W(o_WA1W), .o_WA2W(o_WA2W),
    .o_Result1W(o_Result1W), .o_Result2W(o_Result2W)
`ifdef RETIRE_CNT_EN
    , .o_retire_cnt(o_retire_cnt)
`endif
  );

  task automatic applyStimulus(
    input logic v1, input logic rw1, input logic m1, input logic [DW-1:0] rd1,
    input logic [DW-1:0] alu1, input logic [3:0] wa1,
    input logic v2, input logic rw2, input logic m2, input logic [DW-1:0] rd2,
    input logic [DW-1:0] alu2, input logic [3:0] wa2);
    i_valid1M = v1; i_RegWrite1M = rw1; i_MemtoReg1M = m1; i_RD1 = rd1;
    i_ALUOut1M = alu1; i_WA1M = wa1;
    i_valid2M = v2; i_RegWrite2M = rw2; i_MemtoReg2M = m2; i_RD2 = rd2;
    i_ALUOut2M = alu2; i_WA2M = wa2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change well after the edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; i_stall = 1'b1; i_flush = 1'b1;
    applyStimulus(1, 1, 1, '1, '1, 4'hF, 1, 1, 1, '1, '1, 4'hF);
    tick();
    checkOutput("rst_valid1", 32'(o_valid1W), 0);
    checkOutput("rst_valid2", 32'(o_valid2W), 0);
    checkOutput("rst_rw1", 32'(o_RegWrite1W), 0);
    checkOutput("rst_rw2", 32'(o_RegWrite2W), 0);
    checkOutput("rst_wa1", 32'(o_WA1W), 0);
    checkOutput("rst_wa2", 32'(o_WA2W), 0);
    checkOutput("rst_res1", o_Result1W, 0);
    checkOutput("rst_res2", o_Result2W, 0);
`ifdef RETIRE_CNT_EN
    checkOutput("rst_cnt", o_retire_cnt, 0);
`endif

    $display("[TB] pass-through");
    rst_n = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
    applyStimulus(1, 1, 1, 32'hDEADBEEF, 32'h0000_1111, 4'd3,
                  1, 1, 0, 32'h5555_5555, 32'h0000_0012, 4'd5);
    tick();
    checkOutput("pt_res1", o_Result1W, 32'hDEADBEEF);
    checkOutput("pt_wa1", 32'(o_WA1W), 3);
    checkOutput("pt_res2", o_Result2W, 32'h12);
    checkOutput("pt_wa2", 32'(o_WA2W), 5);
    checkOutput("pt_rw1", 32'(o_RegWrite1W), 1);
    checkOutput("pt_rw2", 32'(o_RegWrite2W), 1);
`ifdef RETIRE_CNT_EN
    checkOutput("pt_cnt", o_retire_cnt, 2);
`endif

    $display("[TB] same-destination conflict");
    applyStimulus(1, 1, 0, 32'h0, 32'hA1, 4'd7, 1, 1, 0, 32'h0, 32'hA2, 4'd7);
    tick();
    checkOutput("cf_rw1", 32'(o_RegWrite1W), 0);
    checkOutput("cf_rw2", 32'(o_RegWrite2W), 1);
    checkOutput("cf_valid1", 32'(o_valid1W), 1);
    checkOutput("cf_res1", o_Result1W, 32'hA1);
    applyStimulus(1, 1, 0, 32'h0, 32'hB1, 4'd7, 1, 1, 0, 32'h0, 32'hB2, 4'd8);
    tick();
    checkOutput("nc_rw1", 32'(o_RegWrite1W), 1);
    checkOutput("nc_rw2", 32'(o_RegWrite2W), 1);
    // Same address but lane 2 not writing: lane 1 keeps its write.
    applyStimulus(1, 1, 0, 32'h0, 32'hC1, 4'd0, 1, 0, 0, 32'h0, 32'hC2, 4'd0);
    tick();
    checkOutput("cf0_rw1", 32'(o_RegWrite1W), 1);
    checkOutput("cf0_rw2", 32'(o_RegWrite2W), 0);
`ifdef RETIRE_CNT_EN
    checkOutput("cf_cnt", o_retire_cnt, 8);
`endif

    $display("[TB] stall and flush");
    applyStimulus(1, 1, 0, 32'h0, 32'h44, 4'd4, 1, 1, 1, 32'h99, 32'h0, 4'd9);
    tick();
    checkOutput("st_cap_wa1", 32'(o_WA1W), 4);
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 32'hFFFF_0000 + i, 32'h0BAD, 4'd12, 0, 0, 0, 32'h0, 32'h0BAD, 4'd13);
      tick();
    end
    checkOutput("st_wa1", 32'(o_WA1W), 4);
    checkOutput("st_wa2", 32'(o_WA2W), 9);
    checkOutput("st_valid1", 32'(o_valid1W), 1);
    checkOutput("st_rw2", 32'(o_RegWrite2W), 1);
    checkOutput("st_res1", o_Result1W, 32'h44);
    checkOutput("st_res2", o_Result2W, 32'h99);
`ifdef RETIRE_CNT_EN
    checkOutput("st_cnt", o_retire_cnt, 10);
`endif
    applyStimulus(1, 1, 0, 32'h0, 32'h0BAD, 4'd12, 1, 1, 0, 32'h0, 32'h0BAD, 4'd13);
    i_flush = 1'b1;
    tick();
    checkOutput("fl_valid1", 32'(o_valid1W), 0);
    checkOutput("fl_valid2", 32'(o_valid2W), 0);
    checkOutput("fl_rw1", 32'(o_RegWrite1W), 0);
    checkOutput("fl_rw2", 32'(o_RegWrite2W), 0);
    checkOutput("fl_wa1", 32'(o_WA1W), 4);
    checkOutput("fl_res2", o_Result2W, 32'h99);
`ifdef RETIRE_CNT_EN
    checkOutput("fl_cnt", o_retire_cnt, 10);
`endif

    $display("[TB] invalid gating");
    i_stall = 1'b0; i_flush = 1'b0;
    applyStimulus(0, 1, 0, 32'h0, 32'h31, 4'd1, 1, 1, 0, 32'h0, 32'h32, 4'd2);
    tick();
    checkOutput("ig_rw1", 32'(o_RegWrite1W), 0);
    checkOutput("ig_valid1", 32'(o_valid1W), 0);
    checkOutput("ig_rw2", 32'(o_RegWrite2W), 1);
`ifdef RETIRE_CNT_EN
    checkOutput("ig_cnt", o_retire_cnt, 11);
`endif

    $display("[TB] reset during stall");
    i_stall = 1'b1;
    applyStimulus(1, 1, 1, 32'h77, 32'h0, 4'd6, 1, 1, 1, 32'h88, 32'h0, 4'd10);
    tick();
    checkOutput("rs_hold_wa1", 32'(o_WA1W), 1);
    rst_n = 1'b0;
    tick();
    checkOutput("rs_valid2", 32'(o_valid2W), 0);
    checkOutput("rs_wa1", 32'(o_WA1W), 0);
    checkOutput("rs_res2", o_Result2W, 0);
    rst_n = 1'b1; i_stall = 1'b0;
    tick();
    checkOutput("rs_cap_res1", o_Result1W, 32'h77);
    checkOutput("rs_cap_wa2", 32'(o_WA2W), 10);
    checkOutput("rs_cap_rw1", 32'(o_RegWrite1W), 1);
`ifdef RETIRE_CNT_EN
    checkOutput("rs_cnt", o_retire_cnt, 2);

    $display("[TB] counter wrap");
    i_stall = 1'b1;
    @(negedge clk);
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.retire_cnt_q;
    i_stall = 1'b0;
    tick();
    checkOutput("wrap_cnt", o_retire_cnt, 32'h0000_0001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
